// File: rtl/rf_ram_host_arb_if.sv
// Host/debug word port of the register-file RAM arbiter.
// The host side drives a request with a register index and write word,
// and the arbiter answers with a one-cycle ack, a read word and a busy flag.
interface rf_ram_host_arb_if #(
    parameter int raw = 6
);
    logic            req;
    logic            we;
    logic [raw-1:0]  reg_idx;
    logic [31:0]     wdata;
    logic            ack;
    logic [31:0]     rdata;
    logic            busy;

    modport master (
        output req, we, reg_idx, wdata,
        input  ack, rdata, busy
    );

    modport slave (
        input  req, we, reg_idx, wdata,
        output ack, rdata, busy
    );
endinterface

// File: rtl/rf_ram_host_arb.sv
// Shares the register-file SRAM between the core's serial RF RAM ports and a
// host/debug word port. The core always wins a port; the host moves whole
// 32-bit registers as a sequence of row beats in cycles the core leaves free.
// Write and read ports are arbitrated independently.
module rf_ram_host_arb #(
    parameter int width    = 16,
    parameter int csr_regs = 4,
    localparam int raw     = $clog2(32 + csr_regs),
    localparam int nbeats  = 32 / width,
    localparam int aw      = raw + $clog2(nbeats)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [aw-1:0]     i_core_waddr,
    input  logic [width-1:0]  i_core_wdata,
    input  logic              i_core_wen,
    input  logic [aw-1:0]     i_core_raddr,
    input  logic              i_core_ren,
    output logic [width-1:0]  o_core_rdata,
    rf_ram_host_arb_if.slave  host,
    output logic [aw-1:0]     o_ram_waddr,
    output logic [width-1:0]  o_ram_wdata,
    output logic              o_ram_wen,
    output logic [aw-1:0]     o_ram_raddr,
    output logic              o_ram_ren,
    input  logic [width-1:0]  i_ram_rdata
);
    // Beat counter needs at least one bit even when a register is a single row.
    localparam int bw    = (nbeats > 1) ? $clog2(nbeats) : 1;
    localparam int nregs = 32 + csr_regs;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RDW,
        DONE
    } state_t;

    state_t            state;
    state_t            state_n;

    // The access direction is remembered by the WR/RD state itself.
    logic [raw-1:0]    reg_l;
    logic [31:0]       wdata_l;
    logic [bw-1:0]     beat;
    logic              cap_valid;
    logic [bw-1:0]     cap_beat;
    logic [31:0]       rdata_q;

    logic              host_wbeat;
    logic              host_rbeat;
    logic              last_beat;
    logic              out_of_range;
    logic              suppress;
    logic [aw-1:0]     host_row;

    assign out_of_range = int'(host.reg_idx) >= nregs;
    assign suppress     = out_of_range || (host.we && (host.reg_idx == '0));
    assign last_beat    = (beat == bw'(nbeats - 1));
    assign host_row     = aw'(int'(reg_l) * nbeats + int'(beat));

    // State register; reset drops any transaction in flight without an ack.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and host beat issue; a host beat only happens when the core
    // leaves the matching port idle in that cycle.
    always_comb begin
        state_n    = state;
        host_wbeat = 1'b0;
        host_rbeat = 1'b0;
        unique case (state)
            IDLE: begin
                if (host.req) begin
                    if (suppress) begin
                        state_n = DONE;
                    end else if (host.we) begin
                        state_n = WR;
                    end else begin
                        state_n = RD;
                    end
                end
            end
            WR: begin
                if (!i_core_wen) begin
                    host_wbeat = 1'b1;
                    if (last_beat) begin
                        state_n = DONE;
                    end
                end
            end
            RD: begin
                if (!i_core_ren) begin
                    host_rbeat = 1'b1;
                    if (last_beat) begin
                        state_n = RDW;
                    end
                end
            end
            RDW: begin
                state_n = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Request latch, beat counter and read-word assembly. The capture flag
    // follows each host read beat by one cycle to match the SRAM read latency.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            reg_l     <= '0;
            wdata_l   <= '0;
            beat      <= '0;
            cap_valid <= 1'b0;
            cap_beat  <= '0;
            rdata_q   <= '0;
        end else begin
            cap_valid <= host_rbeat;
            cap_beat  <= beat;
            if ((state == IDLE) && host.req) begin
                reg_l   <= host.reg_idx;
                wdata_l <= host.wdata;
                beat    <= '0;
                if (out_of_range && !host.we) begin
                    rdata_q <= '0;
                end
            end
            if (host_wbeat || host_rbeat) begin
                beat <= beat + bw'(1);
            end
            if (cap_valid) begin
                rdata_q[int'(cap_beat) * width +: width] <= i_ram_rdata;
            end
        end
    end

    assign o_ram_wen   = i_core_wen | host_wbeat;
    assign o_ram_waddr = i_core_wen ? i_core_waddr : host_row;
    assign o_ram_wdata = i_core_wen ? i_core_wdata : wdata_l[int'(beat) * width +: width];

    assign o_ram_ren   = i_core_ren | host_rbeat;
    assign o_ram_raddr = i_core_ren ? i_core_raddr : host_row;

    assign o_core_rdata = i_ram_rdata;

    assign host.ack   = (state == DONE);
    assign host.busy  = (state != IDLE);
    assign host.rdata = rdata_q;
endmodule

// File: tb/tb_rf_ram_host_arb.sv
// Randomized bench for rf_ram_host_arb. A behavioural SRAM sits on the RAM
// ports; a word-level register model predicts read data, SRAM contents and
// the ack cycle from the core contention pattern of each transaction.
module tb_rf_ram_host_arb;
    localparam int WIDTH = 16;
    localparam int CSR   = 4;
    localparam int N     = 32 / WIDTH;
    localparam int RAW   = 6;
    localparam int AW    = 7;
    localparam int NREG  = 32 + CSR;
    localparam int CORE_REG = 35;

    logic clk = 1'b0;
    logic rst;

    logic [AW-1:0]    core_waddr;
    logic [WIDTH-1:0] core_wdata;
    logic             core_wen;
    logic [AW-1:0]    core_raddr;
    logic             core_ren;
    logic [WIDTH-1:0] core_rdata;
    logic [AW-1:0]    ram_waddr;
    logic [WIDTH-1:0] ram_wdata;
    logic             ram_wen;
    logic [AW-1:0]    ram_raddr;
    logic             ram_ren;
    logic [WIDTH-1:0] ram_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [WIDTH-1:0] ram [0:(1 << AW) - 1];
    logic [31:0]      ref_word [0:NREG-1];
    logic [31:0]      ref_rdata;

    rf_ram_host_arb_if #(.raw(RAW)) host_if ();

    rf_ram_host_arb #(
        .width    (WIDTH),
        .csr_regs (CSR)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_core_waddr (core_waddr),
        .i_core_wdata (core_wdata),
        .i_core_wen   (core_wen),
        .i_core_raddr (core_raddr),
        .i_core_ren   (core_ren),
        .o_core_rdata (core_rdata),
        .host         (host_if.slave),
        .o_ram_waddr  (ram_waddr),
        .o_ram_wdata  (ram_wdata),
        .o_ram_wen    (ram_wen),
        .o_ram_raddr  (ram_raddr),
        .o_ram_ren    (ram_ren),
        .i_ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural dual-port SRAM with one cycle of read latency.
    always @(posedge clk) begin
        if (ram_wen) ram[ram_waddr] <= ram_wdata;
        if (ram_ren) ram_rdata <= ram[ram_raddr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Core writes only ever target the rows of CORE_REG, which the host never touches.
    task automatic driveCore(input logic wen, input logic ren);
        core_wen   = wen;
        core_ren   = ren;
        core_waddr = AW'(CORE_REG * N + $urandom_range(0, N - 1));
        core_wdata = WIDTH'($urandom);
        core_raddr = AW'($urandom);
    endtask

    // One host transaction. pat[c] = core owns the host's port in cycle c;
    // rst_at > 0 pulses reset in that cycle; noise randomizes the other port.
    task automatic applyStimulus(input logic we, input int regn, input logic [31:0] wd,
                                 input logic [31:0] pat, input int rst_at, input bit noise);
        bit          supp;
        int          exp_ack, free, t, last, ack_cyc, n_ack, hb, stray, exp_beats;
        logic [31:0] exp_rd;
        logic        sw, oth;

        supp = (we && regn == 0) || (regn >= NREG);
        free = 0;
        t    = 0;
        if (supp) begin
            exp_ack = 1;
        end else begin
            while (free < N && t < 31) begin
                t++;
                if (!pat[t]) free++;
            end
            exp_ack = t + (we ? 1 : 2);
        end
        if (!we) exp_rd = (regn >= NREG) ? 32'h0 : ref_word[regn];
        else     exp_rd = ref_rdata;

        exp_beats = supp ? 0 : N;
        if (rst_at > 0) begin
            free = 0;
            for (int c = 1; c <= rst_at; c++) if (!pat[c]) free++;
            exp_beats = supp ? 0 : ((free < N) ? free : N);
        end
        last = (rst_at > 0) ? rst_at + 3 : exp_ack + 1;

        host_if.req     = 1'b1;
        host_if.we      = we;
        host_if.reg_idx = RAW'(regn);
        host_if.wdata   = wd;
        driveCore(1'b0, 1'b0);
        @(posedge clk); #1;

        ack_cyc = -1;
        n_ack   = 0;
        hb      = 0;
        stray   = 0;
        for (int c = 1; c <= last; c++) begin
            sw  = (c < 32) ? pat[c] : 1'b0;
            oth = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (we) driveCore(sw, oth);
            else    driveCore(oth, sw);
            if (c == rst_at) begin
                rst         = 1'b1;
                host_if.req = 1'b0;
            end
            @(negedge clk);
            if (host_if.ack) begin
                n_ack++;
                if (ack_cyc < 0) ack_cyc = c;
                checkOutput("ack_rdata", host_if.rdata, exp_rd);
            end
            if (ram_wen && !core_wen) begin
                if (we) begin
                    checkOutput("host_waddr", 32'(ram_waddr), 32'(regn * N + hb));
                    checkOutput("host_wdata", 32'(ram_wdata), 32'(wd[hb * WIDTH +: WIDTH]));
                    hb++;
                end else begin
                    stray++;
                end
            end
            if (ram_ren && !core_ren) begin
                if (!we) begin
                    checkOutput("host_raddr", 32'(ram_raddr), 32'(regn * N + hb));
                    hb++;
                end else begin
                    stray++;
                end
            end
            if (core_wen)
                checkOutput("core_wport", {8'h0, ram_wen, ram_waddr, ram_wdata},
                            {8'h0, 1'b1, core_waddr, core_wdata});
            if (core_ren)
                checkOutput("core_rport", {24'h0, ram_ren, ram_raddr}, {24'h0, 1'b1, core_raddr});
            checkOutput("core_rdata", 32'(core_rdata), 32'(ram_rdata));
            @(posedge clk); #1;
            if (c == rst_at) rst = 1'b0;
            if (ack_cyc > 0) host_if.req = 1'b0;
        end
        host_if.req = 1'b0;
        driveCore(1'b0, 1'b0);

        if (rst_at > 0) begin
            checkOutput("rst_no_ack", 32'(n_ack), 32'd0);
            checkOutput("rst_busy", 32'(host_if.busy), 32'd0);
            checkOutput("rst_rdata", host_if.rdata, 32'h0);
        end else begin
            checkOutput("ack_cycle", 32'(ack_cyc), 32'(exp_ack));
            checkOutput("ack_count", 32'(n_ack), 32'd1);
        end
        checkOutput("host_beats", 32'(hb), 32'(exp_beats));
        checkOutput("stray_beats", 32'(stray), 32'd0);

        if (we && !supp)
            for (int k = 0; k < exp_beats; k++) ref_word[regn][k * WIDTH +: WIDTH] = wd[k * WIDTH +: WIDTH];
        if (rst_at > 0)  ref_rdata = 32'h0;
        else if (!we)    ref_rdata = exp_rd;

        for (int i = 0; i < 50 && host_if.busy; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Watchdog so a stuck design cannot hang the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    // Directed scenarios first, then randomized transactions.
    initial begin
        int          r;
        logic [31:0] pat;

        rst             = 1'b1;
        host_if.req     = 1'b0;
        host_if.we      = 1'b0;
        host_if.reg_idx = '0;
        host_if.wdata   = '0;
        driveCore(1'b0, 1'b0);
        for (int i = 0; i < (1 << AW); i++) ram[i] = WIDTH'($urandom);
        for (int g = 0; g < NREG; g++)
            for (int k = 0; k < N; k++) ref_word[g][k * WIDTH +: WIDTH] = ram[g * N + k];
        ref_rdata = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ack", 32'(host_if.ack), 32'd0);
        checkOutput("reset_busy", 32'(host_if.busy), 32'd0);
        checkOutput("reset_rdata", host_if.rdata, 32'h0);
        checkOutput("reset_strobes", {30'h0, ram_wen, ram_ren}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        applyStimulus(1'b1, 5, 32'hDEADBEEF, 32'h0, 0, 1'b0);
        applyStimulus(1'b0, 5, 32'h0, 32'h0, 0, 1'b0);
        applyStimulus(1'b0, 5, 32'h0, 32'h0000_000E, 0, 1'b0);
        applyStimulus(1'b1, 0, 32'h12345678, 32'h0, 0, 1'b0);
        applyStimulus(1'b0, 0, 32'h0, 32'h0, 0, 1'b0);
        applyStimulus(1'b0, 40, 32'h0, 32'h0, 0, 1'b0);
        applyStimulus(1'b1, 7, 32'hCAFEF00D, 32'h0, 1, 1'b0);
        applyStimulus(1'b0, 7, 32'h0, 32'h0, 0, 1'b0);
        applyStimulus(1'b1, 7, 32'h0BADC0DE, 32'h0, 0, 1'b0);
        applyStimulus(1'b0, 7, 32'h0, 32'h0, 0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) r = $urandom_range(NREG, 63);
            else                           r = $urandom_range(0, CORE_REG - 1);
            pat = $urandom & $urandom & 32'h0000_FFFE;
            applyStimulus(1'($urandom_range(0, 1)), r, $urandom, pat, 0, 1'b1);
        end

        for (int g = 0; g < CORE_REG; g++)
            applyStimulus(1'b0, g, 32'h0, 32'h0, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
